// File: rtl/call_ret_ctrl.sv
// -----------------------------------------------------------------------------
// call_ret_ctrl
//
// Purpose:
//   Sequencer for subroutine CALL / RETURN. It drives the fetch unit's PC
//   load strobe and the push/pop strobes of an external return-address stack.
//   It also keeps its own count of stack occupancy so that it can refuse a
//   call on a full stack or a return on an empty one.
//
//   A call takes one cycle from request to pc_load, and pushes pc_in while
//   doing so. A return waits one cycle (RWAIT) so that the stack's registered
//   top-of-stack can settle. It then loads that value into the PC and pops
//   (RLOAD). Every output is a flop, so all outputs change only on a clock
//   edge or on reset.
//
// Handshake:
//   call and ret are single-cycle level requests. They are sampled on posedge
//   clk, and only while busy=0. While busy=1 any request is dropped silently.
//   No error flag is set and nothing is queued. pc_load, stack_push and
//   stack_pop are one-cycle strobes. pc_out and stack_wdata are valid only
//   in the cycle where their strobe is high, and read as zero otherwise.
//
// Ports:
//   clk           in   clock, all state changes on posedge
//   reset         in   asynchronous, active-high reset (shared with the stack)
//   call, ret     in   call / return requests
//   target_addr   in   call destination, captured with call
//   pc_in         in   current PC, captured with call (pushed as return addr)
//   err_clear     in   clears the sticky error flags
//   stack_rdata   in   registered top-of-stack from the stack
//   pc_load       out  one-cycle strobe: fetch loads pc_out
//   pc_out        out  next PC, valid while pc_load=1
//   busy          out  sequence in progress
//   stack_push    out  push strobe, with stack_wdata
//   stack_pop     out  pop strobe
//   stack_wdata   out  value pushed
//   depth         out  number of entries currently on the stack
//   overflow      out  sticky: call attempted on a full stack
//   underflow     out  sticky: return attempted on an empty stack
//   proto_err     out  sticky: call and ret requested in the same cycle
//   o_dbg_state   out  current FSM state (IDLE=0, PUSH=1, RWAIT=2, RLOAD=3)
// -----------------------------------------------------------------------------
module call_ret_ctrl #(
  parameter int BUS_WIDTH  = 16,
  parameter int STACK_SIZE = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          call,
  input  logic                          ret,
  input  logic [BUS_WIDTH-1:0]          target_addr,
  input  logic [BUS_WIDTH-1:0]          pc_in,
  input  logic                          err_clear,
  output logic                          pc_load,
  output logic [BUS_WIDTH-1:0]          pc_out,
  output logic                          busy,
  output logic                          stack_push,
  output logic                          stack_pop,
  output logic [BUS_WIDTH-1:0]          stack_wdata,
  input  logic [BUS_WIDTH-1:0]          stack_rdata,
  output logic [$clog2(STACK_SIZE):0]   depth,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          proto_err,
  output logic [1:0]                    o_dbg_state
);

  localparam int DEPTH_W = $clog2(STACK_SIZE) + 1;
  localparam logic [DEPTH_W-1:0] FULL  = DEPTH_W'(STACK_SIZE);
  localparam logic [DEPTH_W-1:0] EMPTY = '0;
  localparam logic [DEPTH_W-1:0] ONE   = DEPTH_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH  = 2'd1,
    RWAIT = 2'd2,
    RLOAD = 2'd3
  } state_t;

  // Registered state and outputs
  state_t               r_state;
  logic                 r_pc_load;
  logic [BUS_WIDTH-1:0] r_pc_out;
  logic                 r_busy;
  logic                 r_stack_push;
  logic                 r_stack_pop;
  logic [BUS_WIDTH-1:0] r_stack_wdata;
  logic [DEPTH_W-1:0]   r_depth;
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 r_proto_err;

  // Next-state values
  state_t               w_state_nxt;
  logic                 w_pc_load_nxt;
  logic [BUS_WIDTH-1:0] w_pc_out_nxt;
  logic                 w_busy_nxt;
  logic                 w_stack_push_nxt;
  logic                 w_stack_pop_nxt;
  logic [BUS_WIDTH-1:0] w_stack_wdata_nxt;
  logic [DEPTH_W-1:0]   w_depth_nxt;
  logic                 w_overflow_nxt;
  logic                 w_underflow_nxt;
  logic                 w_proto_err_nxt;

  logic w_full;
  logic w_empty;

  assign w_full  = (r_depth == FULL);
  assign w_empty = (r_depth == EMPTY);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. The outputs are computed for the state
  // being entered and then registered. This is why pc_load is already high
  // in the cycle right after the request edge (PUSH) or after the wait edge
  // (RLOAD).
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_load_nxt     = 1'b0;
    w_pc_out_nxt      = '0;
    w_busy_nxt        = 1'b0;
    w_stack_push_nxt  = 1'b0;
    w_stack_pop_nxt   = 1'b0;
    w_stack_wdata_nxt = '0;
    w_depth_nxt       = r_depth;
    // err_clear drops the flags. An error detected below in the same cycle
    // sets its flag again, so a new error wins over the clear.
    w_overflow_nxt    = r_overflow  & ~err_clear;
    w_underflow_nxt   = r_underflow & ~err_clear;
    w_proto_err_nxt   = r_proto_err & ~err_clear;

    case (r_state)
      IDLE: begin
        if (call && ret) begin
          w_proto_err_nxt = 1'b1;
        end else if (call) begin
          if (w_full) begin
            w_overflow_nxt = 1'b1;
          end else begin
            // Capture pc_in and target_addr straight into the output
            // registers that PUSH presents.
            w_state_nxt       = PUSH;
            w_busy_nxt        = 1'b1;
            w_pc_load_nxt     = 1'b1;
            w_pc_out_nxt      = target_addr;
            w_stack_push_nxt  = 1'b1;
            w_stack_wdata_nxt = pc_in;
            w_depth_nxt       = r_depth + ONE;
          end
        end else if (ret) begin
          if (w_empty) begin
            w_underflow_nxt = 1'b1;
          end else begin
            w_state_nxt = RWAIT;
            w_busy_nxt  = 1'b1;
          end
        end
      end

      PUSH: begin
        w_state_nxt = IDLE;
      end

      RWAIT: begin
        // stack_rdata has had a full cycle to settle. It is sampled here,
        // on entry to RLOAD, and passed through unchanged: any return
        // address offset is applied by the stack.
        w_state_nxt     = RLOAD;
        w_busy_nxt      = 1'b1;
        w_pc_load_nxt   = 1'b1;
        w_pc_out_nxt    = stack_rdata;
        w_stack_pop_nxt = 1'b1;
        w_depth_nxt     = r_depth - ONE;
      end

      RLOAD: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State / output registers. Reset is asynchronous, so a sequence that is in
  // flight is cut off at once and no strobe follows.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc_load     <= 1'b0;
      r_pc_out      <= '0;
      r_busy        <= 1'b0;
      r_stack_push  <= 1'b0;
      r_stack_pop   <= 1'b0;
      r_stack_wdata <= '0;
      r_depth       <= '0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc_load     <= w_pc_load_nxt;
      r_pc_out      <= w_pc_out_nxt;
      r_busy        <= w_busy_nxt;
      r_stack_push  <= w_stack_push_nxt;
      r_stack_pop   <= w_stack_pop_nxt;
      r_stack_wdata <= w_stack_wdata_nxt;
      r_depth       <= w_depth_nxt;
      r_overflow    <= w_overflow_nxt;
      r_underflow   <= w_underflow_nxt;
      r_proto_err   <= w_proto_err_nxt;
    end
  end

  assign pc_load     = r_pc_load;
  assign pc_out      = r_pc_out;
  assign busy        = r_busy;
  assign stack_push  = r_stack_push;
  assign stack_pop   = r_stack_pop;
  assign stack_wdata = r_stack_wdata;
  assign depth       = r_depth;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign proto_err   = r_proto_err;
  assign o_dbg_state = r_state;

  // Structural invariants: push and pop are exclusive, and the occupancy
  // count stays within 0..STACK_SIZE.
  a_no_push_and_pop: assert property (@(posedge clk) disable iff (reset)
    !(r_stack_push && r_stack_pop));
  a_depth_in_range: assert property (@(posedge clk) disable iff (reset)
    (r_depth <= FULL));

endmodule

// File: doc/call_ret_ctrl.md
CALL_RET_CTRL -- requirements
Module: call_ret_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16: width of PC, target and stack data.
REQ-002 SHALL have parameter STACK_SIZE, default 16: entry count of the attached stack; power of two, >= 2.
REQ-003 SHALL have port clk  in  1: single clock; all state changes on posedge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port call  in  1: call request, sampled on posedge.
REQ-006 SHALL have port ret  in  1: return request, sampled on posedge.
REQ-007 SHALL have port target_addr  in  BUS_WIDTH: call destination, sampled with call.
REQ-008 SHALL have port pc_in  in  BUS_WIDTH: current PC, sampled with call.
REQ-009 SHALL have port err_clear  in  1: clears sticky error flags.
REQ-010 SHALL have port pc_load  out  1: one-cycle strobe; fetch loads pc_out.
REQ-011 SHALL have port pc_out  out  BUS_WIDTH: next PC, valid while pc_load=1.
REQ-012 SHALL have port busy  out  1: sequence in progress; requests ignored.
REQ-013 SHALL have port stack_push  out  1: push strobe to stack.
REQ-014 SHALL have port stack_pop  out  1: pop strobe to stack.
REQ-015 SHALL have port stack_wdata  out  BUS_WIDTH: value pushed, valid with stack_push.
REQ-016 SHALL have port stack_rdata  in  BUS_WIDTH: registered top-of-stack from stack.
REQ-017 SHALL have port depth  out  clog2(STACK_SIZE)+1: entries currently on stack.
REQ-018 SHALL have ports overflow, underflow, proto_err  out  1 each: sticky error flags.

Function
REQ-019 SHALL implement FSM states IDLE, PUSH, RWAIT, RLOAD; all outputs registered.
REQ-020 SHALL in IDLE hold busy=0, pc_load=0, stack_push=0, stack_pop=0.
REQ-021 SHALL, IDLE with call=1, ret=0, depth<STACK_SIZE: capture pc_in and target_addr, go to PUSH.
REQ-022 SHALL in PUSH (one cycle) assert stack_push=1, stack_wdata=captured pc_in, pc_load=1, pc_out=captured target, busy=1; depth+1; next IDLE.
REQ-023 SHALL, IDLE with ret=1, call=0, depth>0: go to RWAIT (busy=1, no strobes) to let stack_rdata settle.
REQ-024 SHALL in RLOAD (one cycle) assert pc_load=1, pc_out=stack_rdata sampled at entry, stack_pop=1, busy=1; depth-1; next IDLE.
REQ-025 SHALL pass stack_rdata unchanged; return-address offset is the stack's responsibility.
REQ-026 SHALL give call latency 1 cycle request-to-pc_load and ret latency 2 cycles.
REQ-027 SHALL, call with depth==STACK_SIZE: set overflow, no push, no pc_load, stay IDLE.
REQ-028 SHALL, ret with depth==0: set underflow, no pop, no pc_load, stay IDLE.
REQ-029 SHALL, call=1 and ret=1 same cycle in IDLE: set proto_err, perform neither.
REQ-030 SHALL ignore call/ret while busy=1 without setting any flag.
REQ-031 SHALL never assert stack_push and stack_pop together; depth SHALL never leave 0..STACK_SIZE.
REQ-032 SHALL clear all three flags on err_clear=1; a new error in the same cycle wins (flag stays set).

Reset
REQ-033 SHALL on reset=1, immediately and regardless of clk: state=IDLE, depth=0, all outputs 0, flags 0.
REQ-034 SHALL abort any PUSH/RWAIT/RLOAD on reset mid-sequence with no strobe after reset asserts; stack SHALL share the same reset net.

Verification (BUS_WIDTH=16, STACK_SIZE=4)
REQ-035 SHALL cover: reset; call pc_in=0x0010 target=0x0200 -> next cycle pc_load=1, pc_out=0x0200, stack_push=1, stack_wdata=0x0010, depth=1.
REQ-036 SHALL cover: after REQ-035, ret with stack_rdata=0x0014 -> 2 cycles later pc_load=1, pc_out=0x0014, stack_pop=1, depth=0.
REQ-037 SHALL cover: 4 calls then 5th call -> overflow=1, no push/pc_load, depth=4; err_clear -> overflow=0.
REQ-038 SHALL cover: ret after reset -> underflow=1, stack_pop never asserted, depth=0.
REQ-039 SHALL cover: call and ret same cycle -> proto_err=1, no strobes; call during RWAIT -> ignored, depth unchanged.
REQ-040 SHALL cover: reset asserted mid-RWAIT between clock edges -> busy=0, depth=0 at once, no pc_load follows.
